and_arbiter: RTL
================

AND_ARBITER -- requirements
Module: and_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
REQ-002 clk  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-004 req  input  4  SHALL carry one level request per requester, index 0..3.
REQ-005 a_in  input  4*WIDTH  SHALL carry operand A per requester (requester i at bits [i*WIDTH +: WIDTH]).
REQ-006 b_in  input  4*WIDTH  SHALL carry operand B, packed as a_in.
REQ-007 gnt  output  4  SHALL be a one-hot one-cycle pulse: operands of that requester captured.
REQ-008 done  output  1  SHALL be a one-cycle pulse: result valid on y.
REQ-009 done_id  output  2  SHALL give the requester index owning the current result.
REQ-010 y  output  WIDTH  SHALL give the registered bitwise AND result.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-012 op_count  output  16  SHALL count completed operations.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-014 IDLE with req==0 SHALL stay in IDLE.
REQ-015 IDLE with any req bit set SHALL go to EXEC.
- Winner: first set bit scanning upward from rr_ptr, modulo 4.
- Latches that requester's A and B slices and its index.
REQ-016 In EXEC, gnt[winner] SHALL be 1 for exactly that one cycle; next state DONE.
REQ-017 On the EXEC->DONE edge, y SHALL load latched_A & latched_B (bitwise, WIDTH bits, no carry or extension).
REQ-018 In DONE, done SHALL be 1 and done_id = winner for one cycle; next state IDLE.
REQ-019 Latency SHALL be fixed:
- req sampled in IDLE at edge T.
- gnt high during cycle T..T+1.
- done high during cycle T+1..T+2.
- Earliest next arbitration at edge T+3.
REQ-020 rr_ptr SHALL become (winner+1) mod 4 at the IDLE->EXEC edge; after 3 the pointer wraps to 0.
REQ-021 y and done_id SHALL hold their last values outside DONE; only done marks them valid.
REQ-022 Operand changes after capture SHALL NOT affect y.
REQ-023 req changes while busy SHALL be ignored; only IDLE samples req.
REQ-024 A requester still holding req on return to IDLE SHALL re-compete as a new request under round-robin order.
REQ-025 op_count SHALL increment by 1 in DONE and saturate at 16'hFFFF (no wrap).
REQ-026 Simultaneous requests SHALL yield exactly one gnt bit per operation; gnt SHALL never be multi-hot.

Reset
REQ-027 rst_n low SHALL immediately, without waiting for clk, force:
- state=IDLE, rr_ptr=0
- gnt=0, done=0, done_id=0, y=0, busy=0, op_count=0
REQ-028 Reset asserted mid-operation (EXEC or DONE) SHALL abort it: no done pulse, op_count unchanged from its reset value.
REQ-029 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with state IDLE.

Verification (WIDTH=8)
REQ-030 Single request, req=0001, A0=8'hF0, B0=8'h3C -> gnt=0001 one cycle later, then done=1, done_id=0, y=8'h30, op_count=1.
REQ-031 All four requesting continuously from reset -> grant order 0,1,2,3,0; done every 3 cycles; no multi-hot gnt.
REQ-032 rr_ptr=2 with req=0011 -> grant order 0 then 1.
REQ-033 Operand change after capture: A1 changes from 8'hFF to 8'h00 in the gnt cycle, B1=8'hAA -> y=8'hAA.
REQ-034 rst_n pulsed low during EXEC -> gnt, done, busy, y, op_count all 0 at once; no done pulse; a fresh request then completes normally.
REQ-035 op_count forced to 16'hFFFE, then three operations -> value reads FFFF and holds at FFFF.

Source files
------------

// File: rtl/and_arbiter.sv
// Four-requester round-robin arbiter that captures the winner's operands and
// returns their bitwise AND after a fixed three-cycle IDLE -> EXEC -> DONE sequence.
module and_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  output logic [3:0]           gnt,
  output logic                 done,
  output logic [1:0]           done_id,
  output logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic [15:0]          op_count,
  output logic [1:0]           state_dbg
);

  // Handshake: req is a level sampled only in IDLE; gnt pulses for one cycle when
  // that requester's operands are captured, and done pulses for one cycle when y
  // and done_id are valid. Nothing waits on the requester, so latency is fixed.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q;
  logic [1:0]       win_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       done_id_q;
  logic [15:0]      op_count_q, op_count_d;

  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic [WIDTH-1:0] a_sel, b_sel;

  // Scan upward from rr_ptr, wrapping through the 2-bit index arithmetic.
  always_comb begin
    win   = rr_ptr_q;
    idx   = rr_ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (win == 2'(i)) begin
        a_sel = a_in[i*WIDTH +: WIDTH];
        b_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != 4'b0000) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter register is rewritten every cycle and saturates instead of wrapping.
  always_comb begin
    op_count_d = op_count_q;
    if (state_q == DONE && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd0;
      win_q      <= 2'd0;
      a_q        <= '0;
      b_q        <= '0;
      y_q        <= '0;
      done_id_q  <= 2'd0;
      op_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      op_count_q <= op_count_d;
      if (state_q == IDLE && req != 4'b0000) begin
        win_q    <= win;
        a_q      <= a_sel;
        b_q      <= b_sel;
        rr_ptr_q <= win + 2'd1;
      end
      if (state_q == EXEC) begin
        y_q       <= a_q & b_q;
        done_id_q <= win_q;
      end
    end
  end

  assign gnt       = (state_q == EXEC) ? (4'b0001 << win_q) : 4'b0000;
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign done_id   = done_id_q;
  assign y         = y_q;
  assign op_count  = op_count_q;
  assign state_dbg = state_q;

endmodule
